// File: rtl/aes_axi_master.sv
// ---------------------------------------------------------------------------
// aes_axi_master
//
// AXI4-Lite initiator that lets fabric logic (self-test engine, key loader)
// drive the AES register block without the PS. A one-word command is turned
// into a single AXI4-Lite write or read. Only one transaction is ever in
// flight. The returned BRESP/RRESP is passed back unchanged.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESET   clock, synchronous active-high reset
//   cmd_*                      command in  (valid/ready, we, addr, wdata, wstrb)
//   rsp_*                      response out (valid/ready, rdata, resp)
//   busy                       command accepted, response not yet consumed
//   timeout                    sticky watchdog flag, cleared only by reset
//   dbg_state_o                current FSM state, for monitors and checkers
//   M_AXI_AW*/W*/B*/AR*/R*     AXI4-Lite master channels
//
// Handshake rule on every valid/ready pair (cmd, rsp and all AXI channels):
// a transfer happens on a rising edge where valid && ready are both high.
// A valid, once raised, stays high with its payload stable until that edge.
// This block never waits on an AXI READY before raising the matching VALID.
// ---------------------------------------------------------------------------
module aes_axi_master #(
   parameter int C_M_AXI_ADDR_WIDTH = 7,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES     = 1024
) (
   input  logic                            M_AXI_ACLK,
   input  logic                            M_AXI_ARESET,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_we,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]                      rsp_resp,
   output logic                            busy,
   output logic                            timeout,
   output logic [2:0]                      dbg_state_o,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
);

   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;
   localparam int SW = C_M_AXI_DATA_WIDTH / 8;

   // Watchdog counter wide enough to hold TIMEOUT_CYCLES; a limit of 0 turns
   // the watchdog off entirely.
   localparam bit      WD_EN = (TIMEOUT_CYCLES != 0);
   localparam int      CW    = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] WD_LIMIT = TIMEOUT_CYCLES[CW-1:0];

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      WR_B = 3'd2,
      RD_A = 3'd3,
      RD_D = 3'd4,
      RSP  = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic            cmd_ready_q, cmd_ready_d;
   logic            awvalid_q, awvalid_d;
   logic            wvalid_q, wvalid_d;
   logic            bready_q, bready_d;
   logic            arvalid_q, arvalid_d;
   logic            rready_q, rready_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]      rsp_resp_q, rsp_resp_d;
   logic            busy_q, busy_d;
   logic            timeout_q, timeout_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]   wstrb_q, wstrb_d;
   logic [CW-1:0]   wd_cnt_q, wd_cnt_d;
   logic            accept;
   logic            waiting;

   always_comb begin
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      wd_cnt_d    = wd_cnt_q;
      timeout_d   = timeout_q;
      accept      = 1'b0;
      waiting     = 1'b0;

      case (state_q)
         IDLE: begin
            accept = cmd_valid && cmd_ready_q;
            if (accept) begin
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               wstrb_d = cmd_wstrb;
               if (cmd_we) begin
                  state_d   = WR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d = RD_A;
               end
            end
         end
         WR: begin
            waiting = 1'b1;
            // AW and W retire independently; leave once both are gone,
            // which also covers both completing on the same edge.
            if (M_AXI_AWREADY) awvalid_d = 1'b0;
            if (M_AXI_WREADY)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) state_d = WR_B;
         end
         WR_B: begin
            waiting = 1'b1;
            if (M_AXI_BVALID) begin
               rsp_resp_d  = M_AXI_BRESP;
               rsp_rdata_d = '0;
               state_d     = RSP;
            end
         end
         RD_A: begin
            waiting = 1'b1;
            if (M_AXI_ARREADY) state_d = RD_D;
         end
         RD_D: begin
            waiting = 1'b1;
            if (M_AXI_RVALID) begin
               rsp_resp_d  = M_AXI_RRESP;
               rsp_rdata_d = M_AXI_RDATA;
               state_d     = RSP;
            end
         end
         RSP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // All interface strobes are registered copies of the next state, so a
      // VALID/READY is high exactly while the FSM sits in its state.
      arvalid_d   = (state_d == RD_A);
      bready_d    = (state_d == WR_B);
      rready_d    = (state_d == RD_D);
      rsp_valid_d = (state_d == RSP);
      cmd_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);

      // Watchdog only flags; aborting would leave the slave mid-transfer.
      if (accept) begin
         wd_cnt_d = '0;
      end else if (WD_EN && waiting && (wd_cnt_q != WD_LIMIT)) begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
      if (WD_EN && (wd_cnt_d == WD_LIMIT) && !accept) timeout_d = 1'b1;
   end

   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         wd_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         wd_cnt_q    <= wd_cnt_d;
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign busy          = busy_q;
   assign timeout       = timeout_q;
   assign dbg_state_o   = state_q;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule
